i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: ADDRESS, 7'h27, 7-bit target address the block responds to.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth applied to scl_in and sda_in.
REQ-003 clk  input  1  single system clock; every flop is on its rising edge; must run at 8x or more the bus SCL rate.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl_in  input  1  bus SCL level, asynchronous to clk.
REQ-006 sda_in  input  1  bus SDA level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 rx_data  output  8  last byte received in a write transfer, MSB first on bus.
REQ-009 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-010 tx_data  input  8  byte to return in a read transfer; sampled on the tx_load pulse.
REQ-011 tx_load  output  1  one-clk pulse when tx_data is captured into the shift register.
REQ-012 busy  output  1  high from matched-address ACK until STOP or repeated START.

Function
REQ-013 scl_in/sda_in pass through SYNC_STAGES flops; SCL rise, SCL fall, START and STOP are detected on the synchronized signals one clk after the edge.
REQ-014 START = synchronized SDA falls while SCL high; STOP = SDA rises while SCL high; either one overrides every state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, SKIP.
REQ-016 IDLE: sda_oe=0; START -> ADDR with bit counter=7.
REQ-017 ADDR: shift SDA in on each SCL rise; after the 8th rise, compare bits[7:1] with ADDRESS; bit[0] = R/W (1 = read).
REQ-018 Address match: on the next SCL fall assert sda_oe=1 and enter ADDR_ACK; mismatch: keep sda_oe=0 and enter SKIP.
REQ-019 ADDR_ACK: release on the SCL fall after the ACK clock; write -> RX; read -> load tx_data, pulse tx_load, drive bit 7, enter TX.
REQ-020 RX: shift 8 bits on SCL rises; after the 8th, rx_data updates and rx_valid pulses in the same clk; ACK pulled on the next SCL fall (RX_ACK), released on the fall after; then RX again.
REQ-021 TX: sda_oe = ~shift[7], updated only on SCL falls; after the 8th bit release SDA and enter TX_ACK.
REQ-022 TX_ACK: sample SDA on SCL rise; 0 (ACK) -> reload tx_data, pulse tx_load, TX; 1 (NACK) -> SKIP with SDA released.
REQ-023 SKIP: sda_oe=0, ignore everything except START (-> ADDR) and STOP (-> IDLE).
REQ-024 Repeated START in any state: sda_oe released the same clk, counter=7, state ADDR; busy drops.
REQ-025 STOP in any state: sda_oe=0, state IDLE, busy=0; a partial byte is discarded with no rx_valid.
REQ-026 sda_oe changes only on a synchronized SCL fall, a START, a STOP, or reset; never while SCL is high.
REQ-027 Address 7'h00 (general call) gets no ACK.
REQ-028 rx_valid and tx_load are never asserted in the same clk.

Reset
REQ-029 On reset assertion, immediately: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counter=7, synchronizer flops=1.
REQ-030 Reset asserted mid-transfer releases SDA immediately; after deassertion the block waits for a new START and ignores bus activity until then.

Verification
REQ-031 Write 0x4E (addr 0x27, W), then data 0xA5, then STOP -> ACK after the address and after the data; rx_data=0xA5 with exactly one rx_valid pulse; busy returns to 0 after STOP.
REQ-032 Address 0x28 W, then byte 0x55 -> sda_oe stays 0 throughout; no rx_valid; state SKIP until STOP.
REQ-033 Read 0x4F with tx_data=0x3C, master ACKs then NACKs -> bits 0x3C driven, tx_load pulses twice, SDA released after the NACK.
REQ-034 Write addr 0x27, 3 data bits, repeated START, 0x4F -> no rx_valid; address re-decoded; ACK; TX entered.
REQ-035 Reset asserted while sda_oe=1 during a data ACK -> sda_oe=0 in the same cycle; the next bytes are ignored until a fresh START.
REQ-036 Back-to-back write of 0x01, 0xFF, 0x80 -> three rx_valid pulses carrying those values in order; each byte ACKed.

Source files
------------

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: I2C target (slave) with a fixed 7-bit address.
// All bus sampling happens on synchronized copies of SCL/SDA in the clk domain,
// so clk must run at 8x or more the SCL rate.
//
// Ports
//   clk      system clock, all flops on its rising edge
//   reset    asynchronous, active-high reset
//   scl_in   bus SCL level (asynchronous)
//   sda_in   bus SDA level (asynchronous)
//   sda_oe   1 = pull SDA low, 0 = release (open drain)
//   rx_data  last byte received in a write transfer
//   rx_valid one-clk pulse when rx_data updates
//   tx_data  byte to return in a read transfer, sampled while tx_load is high
//   tx_load  one-clk pulse in the clk where tx_data is captured
//   busy     high from a matched-address ACK until STOP or repeated START
module i2c_target #(
    parameter logic [6:0]  ADDRESS     = 7'h27,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTx,
        StTxAck,
        StSkip
    } state_e;

    // Synchronizers plus one delayed copy for edge detection; all reset to the
    // idle bus level so reset release never looks like a START.
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= (scl_sync_q << 1) | SYNC_STAGES'(scl_in);
            sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(sda_in);
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;  // 8th bit shifted, waiting for SCL fall
    logic       tx_first_q, tx_first_d;    // reloaded byte: next fall drives bit 7
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;

    logic [7:0] shift_in;
    logic       addr_match;

    assign shift_in   = {shift_q[6:0], sda_s};
    // General call (address 0) is never acknowledged.
    assign addr_match = (shift_q[7:1] == ADDRESS) && (shift_q[7:1] != 7'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd7;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            tx_first_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            tx_first_q  <= tx_first_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        tx_first_d  = tx_first_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        busy_d      = busy_q;
        tx_load     = 1'b0;

        if (start_det) begin
            state_d     = StAddr;
            cnt_d       = 3'd7;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else if (stop_det) begin
            state_d     = StIdle;
            cnt_d       = 3'd7;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sda_oe_d = 1'b0;
                end
                StAddr: begin
                    if (scl_rise && !byte_done_q) begin
                        shift_d = shift_in;
                        if (cnt_q == 3'd0) begin
                            byte_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (addr_match) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = StAddrAck;
                        end else begin
                            state_d = StSkip;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        if (shift_q[0]) begin
                            // Read: bit 7 goes on the bus on this same fall.
                            shift_d    = tx_data;
                            tx_load    = 1'b1;
                            sda_oe_d   = ~tx_data[7];
                            tx_first_d = 1'b0;
                            state_d    = StTx;
                        end else begin
                            state_d = StRx;
                        end
                    end
                end
                StRx: begin
                    if (scl_rise && !byte_done_q) begin
                        shift_d = shift_in;
                        if (cnt_q == 3'd0) begin
                            byte_done_d = 1'b1;
                            rx_data_d   = shift_in;
                            rx_valid_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b1;
                        state_d     = StRxAck;
                    end
                end
                StRxAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        state_d  = StRx;
                    end
                end
                StTx: begin
                    if (scl_fall) begin
                        if (tx_first_q) begin
                            tx_first_d = 1'b0;
                            sda_oe_d   = ~shift_q[7];
                        end else if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = StTxAck;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q - 3'd1;
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            // Reload now; bit 7 is driven on the coming fall.
                            shift_d    = tx_data;
                            tx_load    = 1'b1;
                            tx_first_d = 1'b1;
                            cnt_d      = 3'd7;
                            state_d    = StTx;
                        end else begin
                            state_d = StSkip;
                        end
                    end
                end
                StSkip: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule
